// File: rtl/wb_shared_bus_arbiter.sv
// Round-robin Wishbone arbiter for a shared-bus master port.
// Optional hung-cycle watchdog when WB_ARB_TIMEOUT_EN is defined.
module wb_shared_bus_arbiter #(
  parameter int WB_N_MASTERS_g = 2,
  parameter int WB_AWIDTH_g    = 16,
  parameter int WB_TIMEOUT_g   = 255
) (
  input  logic                                  CLK_i,
  input  logic                                  RST_i,
  input  logic                                  CLK_EN_i,
  input  logic [WB_N_MASTERS_g*WB_AWIDTH_g-1:0] WBM_ADR_i,
  input  logic [WB_N_MASTERS_g*8-1:0]           WBM_DAT_i,
  input  logic [WB_N_MASTERS_g-1:0]             WBM_WE_i,
  input  logic [WB_N_MASTERS_g-1:0]             WBM_STB_i,
  input  logic [WB_N_MASTERS_g-1:0]             WBM_CYC_i,
  output logic [7:0]                            WBM_DAT_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_ACK_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_ERR_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_RTY_o,
  output logic [WB_N_MASTERS_g-1:0]             GNT_o,
  output logic [WB_AWIDTH_g-1:0]                BUS_ADR_o,
  output logic [7:0]                            BUS_DAT_o,
  output logic                                  BUS_WE_o,
  output logic                                  BUS_STB_o,
  output logic                                  BUS_CYC_o,
  input  logic [7:0]                            BUS_DAT_i,
  input  logic                                  BUS_ACK_i,
  input  logic                                  BUS_ERR_i,
  input  logic                                  BUS_RTY_i
);

  localparam int N  = WB_N_MASTERS_g;
  localparam int AW = WB_AWIDTH_g;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef logic [PW-1:0] ptr_t;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  ptr_t            ptr_q, ptr_d;
  ptr_t            win_idx;
  logic            win_found;
  logic            owned;
  logic            own_cyc;
  logic            own_stb;
  int              cand;
  int              own_idx;
  logic            wdt_hit;

  // The pointer always names the current owner while a grant is held.
  assign owned   = |gnt_q;
  assign own_idx = int'(ptr_q);

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr_q) + i) % N;
      if (!win_found && WBM_CYC_i[cand]) begin
        win_found = 1'b1;
        win_idx   = ptr_t'(cand);
      end
    end
  end

  always_comb begin
    BUS_ADR_o = '0;
    BUS_DAT_o = '0;
    BUS_WE_o  = 1'b0;
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    if (owned) begin
      BUS_ADR_o = WBM_ADR_i[own_idx*AW +: AW];
      BUS_DAT_o = WBM_DAT_i[own_idx*8 +: 8];
      BUS_WE_o  = WBM_WE_i[own_idx];
      own_cyc   = WBM_CYC_i[own_idx];
      own_stb   = WBM_STB_i[own_idx];
    end
  end

  assign BUS_CYC_o = own_cyc;
  assign BUS_STB_o = own_stb & own_cyc;
  assign GNT_o     = gnt_q;
  assign WBM_DAT_o = BUS_DAT_i;
  assign WBM_ACK_o = {N{BUS_ACK_i}} & gnt_q;
  assign WBM_RTY_o = {N{BUS_RTY_i}} & gnt_q;
  assign WBM_ERR_o = {N{BUS_ERR_i | wdt_hit}} & gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (CLK_EN_i) begin
      unique case (state_q)
        IDLE: begin
          gnt_d = '0;
          if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            ptr_d          = win_idx;
            state_d        = OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= ptr_t'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wdt_q, wdt_d;
  logic        any_rsp;

  assign any_rsp = BUS_ACK_i | BUS_ERR_i | BUS_RTY_i;
  assign wdt_hit = (state_q == OWNED) &&
                   (wdt_q == 16'(WB_TIMEOUT_g));

  // Counts only stalled strobes; the terminating ERR beat restarts it.
  always_comb begin
    wdt_d = wdt_q;
    if (CLK_EN_i) begin
      if (state_d != OWNED || state_q != OWNED ||
          !BUS_STB_o || any_rsp || wdt_hit)
        wdt_d = '0;
      else
        wdt_d = wdt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end
`else
  assign wdt_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// Scoreboard bench for wb_shared_bus_arbiter (2 masters, 16-bit address).
// Expected values are queued when stimulus is driven and popped at check.
module tb_wb_shared_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic [N*AW-1:0] m_adr;
  logic [N*8-1:0]  m_dat;
  logic [N-1:0]    m_we, m_stb, m_cyc;
  logic [7:0]      m_dat_o;
  logic [N-1:0]    m_ack, m_err, m_rty, gnt;
  logic [AW-1:0]   b_adr;
  logic [7:0]      b_dat_o;
  logic            b_we, b_stb, b_cyc;
  logic [7:0]      b_dat_i;
  logic            b_ack, b_err, b_rty;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  wb_shared_bus_arbiter #(
    .WB_N_MASTERS_g(N),
    .WB_AWIDTH_g(AW),
    .WB_TIMEOUT_g(TO)
  ) dut (
    .CLK_i(clk), .RST_i(rst), .CLK_EN_i(clk_en),
    .WBM_ADR_i(m_adr), .WBM_DAT_i(m_dat), .WBM_WE_i(m_we),
    .WBM_STB_i(m_stb), .WBM_CYC_i(m_cyc),
    .WBM_DAT_o(m_dat_o), .WBM_ACK_o(m_ack), .WBM_ERR_o(m_err),
    .WBM_RTY_o(m_rty), .GNT_o(gnt),
    .BUS_ADR_o(b_adr), .BUS_DAT_o(b_dat_o), .BUS_WE_o(b_we),
    .BUS_STB_o(b_stb), .BUS_CYC_o(b_cyc),
    .BUS_DAT_i(b_dat_i), .BUS_ACK_i(b_ack),
    .BUS_ERR_i(b_err), .BUS_RTY_i(b_rty)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clk_en = 1'b1; m_adr = '0; m_dat = '0; m_we = '0;
    m_stb = '0; m_cyc = '0; b_dat_i = '0;
    b_ack = 0; b_err = 0; b_rty = 0;
    m_adr[AW +: AW] = 16'hBEEF;
    m_cyc[1] = 1'b1;
    do_reset();
    exp_q.push_back({30'd0, 2'b00});
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL reset_gnt got=%b want=%b", gnt, exp[1:0]);
    end
    checks++;
    if ({b_cyc, b_stb, b_adr} !== 18'd0) begin
      errors++;
      $display("FAIL reset_bus got=%h want=0", {b_cyc, b_stb, b_adr});
    end
    m_cyc = '0;
  endtask

  task automatic test_single();
    m_adr[0 +: AW] = 16'h0012;
    m_dat[0 +: 8]  = 8'h3C;
    m_we[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[0] = 1'b1;
    exp_q.push_back({30'd0, 2'b01});
    exp_q.push_back({14'd0, 2'b11, 16'h0012});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL single_gnt got=%b want=%b", gnt, exp[1:0]);
    end
    exp = exp_q.pop_front(); checks++;
    if ({b_cyc, b_stb, b_adr} !== exp[17:0]) begin
      errors++;
      $display("FAIL single_bus got=%h want=%h",
               {b_cyc, b_stb, b_adr}, exp[17:0]);
    end
    b_ack = 1'b1; b_dat_i = 8'hA5;
    exp_q.push_back({22'd0, 8'hA5, 2'b01});
    #1;
    exp = exp_q.pop_front(); checks++;
    if ({m_dat_o, m_ack} !== exp[9:0]) begin
      errors++;
      $display("FAIL single_ack got=%h want=%h",
               {m_dat_o, m_ack}, exp[9:0]);
    end
    step();
    b_ack = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    exp_q.push_back({30'd0, 2'b00});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL single_release got=%b want=%b", gnt, exp[1:0]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    exp_q.push_back({30'd0, 2'b01});
    exp_q.push_back({30'd0, 2'b00});
    exp_q.push_back({30'd0, 2'b10});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL rr_first got=%b want=%b", gnt, exp[1:0]);
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL rr_idle got=%b want=%b", gnt, exp[1:0]);
    end
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL rr_second got=%b want=%b", gnt, exp[1:0]);
    end
    checks++;
    if (b_adr !== 16'hBEEF) begin
      errors++;
      $display("FAIL rr_adr got=%h want=beef", b_adr);
    end
    m_cyc = '0; m_stb = '0;
    step();
  endtask

  task automatic test_no_preempt();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    b_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({28'd0, 2'b01, 2'b01});
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({gnt, m_ack} !== exp[3:0]) begin
        errors++;
        $display("FAIL burst_beat%0d got=%b want=%b",
                 i, {gnt, m_ack}, exp[3:0]);
      end
      step();
    end
    b_ack = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    exp_q.push_back({30'd0, 2'b00});
    exp_q.push_back({30'd0, 2'b10});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL burst_gap got=%b want=%b", gnt, exp[1:0]);
    end
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL burst_next got=%b want=%b", gnt, exp[1:0]);
    end
    m_cyc = '0; m_stb = '0;
    step();
  endtask

  task automatic test_clk_en();
    clk_en = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({30'd0, 2'b00});
      step();
      exp = exp_q.pop_front(); checks++;
      if (gnt !== exp[1:0]) begin
        errors++;
        $display("FAIL clken_hold%0d got=%b want=%b", i, gnt, exp[1:0]);
      end
    end
    clk_en = 1'b1;
    exp_q.push_back({30'd0, 2'b01});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL clken_grant got=%b want=%b", gnt, exp[1:0]);
    end
    m_cyc = '0; m_stb = '0;
    step();
  endtask

  task automatic test_rst_mid();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    exp_q.push_back({30'd0, 2'b10});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL rstmid_pre got=%b want=%b", gnt, exp[1:0]);
    end
    rst = 1'b1;
    exp_q.push_back({29'd0, 1'b0, 2'b00});
    step();
    exp = exp_q.pop_front(); checks++;
    if ({b_cyc, gnt} !== exp[2:0]) begin
      errors++;
      $display("FAIL rstmid_drop got=%b want=%b", {b_cyc, gnt}, exp[2:0]);
    end
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    exp_q.push_back({30'd0, 2'b01});
    step();
    exp = exp_q.pop_front(); checks++;
    if (gnt !== exp[1:0]) begin
      errors++;
      $display("FAIL rstmid_first got=%b want=%b", gnt, exp[1:0]);
    end
    m_cyc = '0; m_stb = '0;
    step();
  endtask

  task automatic test_timeout();
    logic e;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    for (int i = 1; i <= 12; i++) begin
`ifdef WB_ARB_TIMEOUT_EN
      e = (i == TO);
`else
      e = 1'b0;
`endif
      exp_q.push_back({28'd0, 2'b01, 1'b0, e});
      step();
      exp = exp_q.pop_front(); checks++;
      if ({gnt, m_err} !== exp[3:0]) begin
        errors++;
        $display("FAIL timeout_clk%0d got=%b want=%b",
                 i, {gnt, m_err}, exp[3:0]);
      end
    end
    m_cyc = '0; m_stb = '0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_clk_en();
    test_rst_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus_arbiter.md
Name: wb_shared_bus_arbiter

Overview:
- Round-robin arbiter granting one of N 8-bit Wishbone masters ownership of the shared-bus interconnect's single master port.
- Sits between the CPU/DMA-class masters and the shared-bus address decoder/interconnect. Holds the grant for the whole CYC burst.
- Routes the owner's request signals to the bus and the bus responses back to the owner only.
- Optional watchdog terminates hung cycles with ERR.

Parameters:
- WB_N_MASTERS_g, 2, number of requesting masters (2..8)
- WB_AWIDTH_g, 16, address width on the shared bus
- WB_TIMEOUT_g, 255, watchdog limit in enabled clocks (watchdog build only; 1..65535)

Ports:
- CLK_i  in  1  system clock
- RST_i  in  1  reset, synchronous, active-high
- CLK_EN_i  in  1  clock enable; state, pointer and counter advance only when high
- WBM_ADR_i  in  N*AWIDTH  packed master addresses, master k at [k*AWIDTH +: AWIDTH]
- WBM_DAT_i  in  N*8  packed master write data
- WBM_WE_i  in  N  per-master write enable
- WBM_STB_i  in  N  per-master strobe
- WBM_CYC_i  in  N  per-master cycle (bus request)
- WBM_DAT_o  out  8  read data broadcast to all masters (shared bus data)
- WBM_ACK_o  out  N  per-master acknowledge
- WBM_ERR_o  out  N  per-master error
- WBM_RTY_o  out  N  per-master retry
- GNT_o  out  N  one-hot grant, registered
- BUS_ADR_o  out  AWIDTH  to interconnect
- BUS_DAT_o  out  8  to interconnect
- BUS_WE_o  out  1  to interconnect
- BUS_STB_o  out  1  to interconnect
- BUS_CYC_o  out  1  to interconnect
- BUS_DAT_i  in  8  from interconnect
- BUS_ACK_i  in  1  from interconnect
- BUS_ERR_i  in  1  from interconnect
- BUS_RTY_i  in  1  from interconnect

Behaviour:
- FSM states: IDLE, OWNED. Reset: state=IDLE, GNT_o=0, last-owner pointer=N-1 (so master 0 wins first), watchdog count=0.
- IDLE, CLK_EN_i=1, any WBM_CYC_i high: winner is the first requester searching upward from pointer+1 modulo N.
  - Next clock: GNT_o=onehot(winner), pointer=winner, state=OWNED.
  - Grant latency: 1 enabled clock from CYC assertion.
- IDLE, no request: stay in IDLE; GNT_o=0.
- OWNED: grant held while owner's WBM_CYC_i=1. Requests from other masters are ignored (no preemption).
- OWNED, owner CYC=0 (sampled, CLK_EN_i=1): next clock GNT_o=0, state=IDLE.
  - Minimum one idle clock between owners; a new grant is issued the clock after that.
- Bus outputs are combinational from GNT_o and the owner's inputs:
  - BUS_ADR_o, BUS_DAT_o, BUS_WE_o = owner's values; all zero when no grant.
  - BUS_STB_o = owner STB & owner CYC; BUS_CYC_o = owner CYC.
- Responses: WBM_ACK_o/ERR_o/RTY_o[k] = BUS_*_i & GNT_o[k]. Non-owners always see 0. WBM_DAT_o = BUS_DAT_i unconditionally.
- Fairness: with all N masters continuously requesting and releasing after one cycle, grants rotate 0,1,..,N-1,0.
- Simultaneous owner release and new request: release is processed first (IDLE), then arbitration. The releasing master has lowest priority next round.
- CLK_EN_i=0 freezes state, GNT_o, pointer and counter. Combinational routing continues.
- Reset mid-cycle: grant dropped at next edge; bus outputs go to zero the same clock GNT_o clears.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each enabled clock in OWNED while BUS_STB_o=1 and ACK/ERR/RTY all 0.
  - Counter clears on any response, when STB=0, or on leaving OWNED.
  - When count == WB_TIMEOUT_g, WBM_ERR_o[owner] is forced high for exactly that one clock and the counter clears. The grant remains until the owner drops CYC.
- Undefined: no counter logic; ERR is pure passthrough.

Test Plan:
- Reset, then M0 CYC/STB with ADR=0x0012 -> GNT_o=0b01 one clock later; BUS_ADR_o=0x0012; BUS_ACK_i pulse reaches WBM_ACK_o[0] only.
- M0 and M1 request simultaneously after reset -> M0 granted first. M0 drops CYC -> one idle clock, then GNT_o=0b10.
- M1 requests while M0 holds a 4-beat burst -> M1 never sees ACK, GNT_o stays 0b01 for all 4 beats.
- CLK_EN_i low for 3 clocks during an IDLE request -> no grant until CLK_EN_i returns high, then grant 1 clock later.
- Assert RST_i mid-burst with GNT_o=0b10 -> next clock GNT_o=0, BUS_CYC_o=0, and the first grant after reset goes to M0.
- WB_ARB_TIMEOUT_EN defined, WB_TIMEOUT_g=8, slave never acks -> WBM_ERR_o[owner]=1 for one clock, 8 enabled clocks after STB asserts.
  - Same test without the macro -> no ERR, bus stays stalled.
